// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall controller: forwarding selects,
// divide-sequencer state encoding and the register-match helper.
package hazard_stall_unit_pkg;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } div_state_t;

   // $0 is hard-wired to zero, so a match on it never creates a dependency
   function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

endpackage

// File: rtl/hazard_stall_unit_div_sequencer.sv
// Sequences the iterative divider: start pulse, busy window, and a done
// pulse that is held while the memory side keeps the pipe frozen.
module div_sequencer
   import hazard_stall_unit_pkg::*;
#(
   parameter int DIV_LATENCY = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic divE,
   input  logic hold,
   output logic div_start,
   output logic div_busy,
   output logic div_done
);

   localparam int CW = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LATENCY - 1);

   div_state_t    r_state;
   div_state_t    w_nextState;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_nextCnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= DIV_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   // The start cycle already counts as busy so the pipe freezes immediately
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      div_start   = 1'b0;
      div_busy    = 1'b0;
      div_done    = 1'b0;
      if (rst) begin
         case (r_state)
            DIV_IDLE: begin
               if (divE) begin
                  div_start   = 1'b1;
                  div_busy    = 1'b1;
                  w_nextCnt   = CNT_INIT;
                  w_nextState = DIV_BUSY;
               end
            end
            DIV_BUSY: begin
               div_busy = 1'b1;
               if (r_cnt == '0) begin
                  w_nextState = DIV_DONE;
               end else begin
                  w_nextCnt = r_cnt - CW'(1);
               end
            end
            DIV_DONE: begin
               div_done = 1'b1;
               if (!hold) begin
                  w_nextState = DIV_IDLE;
               end
            end
            default: w_nextState = DIV_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller for the 5-stage MIPS core: operand forwarding,
// load-use and branch stalls, and whole-pipe freeze for memory waits and divides.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int DIV_LATENCY = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rsD,
   input  logic [4:0] rtD,
   input  logic [4:0] rsE,
   input  logic [4:0] rtE,
   input  logic [4:0] writeregE,
   input  logic [4:0] writeregM,
   input  logic [4:0] writeregW,
   input  logic       regwriteE,
   input  logic       regwriteM,
   input  logic       regwriteW,
   input  logic       memtoregE,
   input  logic       memtoregM,
   input  logic       branchD,
   input  logic       jalrD,
   input  logic       hiloreadE,
   input  logic       hilowriteM,
   input  logic       hilowriteW,
   input  logic       divE,
   input  logic       dmem_stall,
   output logic       forwardAD,
   output logic       forwardBD,
   output logic [1:0] forwardAE,
   output logic [1:0] forwardBE,
   output logic [1:0] forwardhiloE,
   output logic       stallF,
   output logic       stallD,
   output logic       stallE,
   output logic       stallM,
   output logic       stallW,
   output logic       flushE,
   output logic       div_start,
   output logic       div_done
);

   logic w_divBusy;
   logic w_lwStall;
   logic w_brStall;
   logic w_memHold;

   div_sequencer #(.DIV_LATENCY(DIV_LATENCY)) u_divSeq (
      .clk       (clk),
      .rst       (rst),
      .divE      (divE),
      .hold      (dmem_stall),
      .div_start (div_start),
      .div_busy  (w_divBusy),
      .div_done  (div_done)
   );

   assign w_lwStall = memtoregE && ((rtE == rsD) || (rtE == rtD));
   assign w_brStall = (branchD || jalrD) &&
                      ((regwriteE && (regMatch(writeregE, rsD) || regMatch(writeregE, rtD))) ||
                       (memtoregM && (regMatch(writeregM, rsD) || regMatch(writeregM, rtD))));
   assign w_memHold = dmem_stall || w_divBusy;

   // M-stage results take priority over W since they are younger
   always_comb begin
      forwardAE    = FWD_NONE;
      forwardBE    = FWD_NONE;
      forwardhiloE = FWD_NONE;
      forwardAD    = 1'b0;
      forwardBD    = 1'b0;
      if (rst) begin
         if (regwriteM && regMatch(rsE, writeregM))      forwardAE = FWD_MEM;
         else if (regwriteW && regMatch(rsE, writeregW)) forwardAE = FWD_WB;
         if (regwriteM && regMatch(rtE, writeregM))      forwardBE = FWD_MEM;
         else if (regwriteW && regMatch(rtE, writeregW)) forwardBE = FWD_WB;
         if (hiloreadE && hilowriteM) forwardhiloE = FWD_MEM;
         else if (hilowriteW)         forwardhiloE = FWD_WB;
         forwardAD = regwriteM && regMatch(rsD, writeregM);
         forwardBD = regwriteM && regMatch(rtD, writeregM);
      end
   end

   // A frozen pipe must not also bubble E, so memory hold outranks hazards
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      stallW = 1'b0;
      flushE = 1'b0;
      if (rst) begin
         if (w_memHold) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            stallW = 1'b1;
         end else if (w_lwStall || w_brStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios with literal
// expectations, then randomized traffic against a cycle-count reference model.
module tb_hazard_stall_unit;

   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [4:0] rsD = '0, rtD = '0, rsE = '0, rtE = '0;
   logic [4:0] writeregE = '0, writeregM = '0, writeregW = '0;
   logic regwriteE = 0, regwriteM = 0, regwriteW = 0, memtoregE = 0, memtoregM = 0;
   logic branchD = 0, jalrD = 0, hiloreadE = 0, hilowriteM = 0, hilowriteW = 0;
   logic divE = 0, dmem_stall = 0;
   logic forwardAD, forwardBD;
   logic [1:0] forwardAE, forwardBE, forwardhiloE;
   logic stallF, stallD, stallE, stallM, stallW, flushE, div_start, div_done;

   int checks = 0;
   int errors = 0;
   int startSeen = 0;
   // -1 when no divide is pending, otherwise cycles elapsed since the start pulse
   int mDiv = -1;

   logic [15:0] dutVec;
   assign dutVec = {forwardAD, forwardBD, forwardAE, forwardBE, forwardhiloE,
                    stallF, stallD, stallE, stallM, stallW, flushE, div_start, div_done};

   hazard_stall_unit #(.DIV_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
      .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
      .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD), .jalrD(jalrD),
      .hiloreadE(hiloreadE), .hilowriteM(hilowriteM), .hilowriteW(hilowriteW),
      .divE(divE), .dmem_stall(dmem_stall),
      .forwardAD(forwardAD), .forwardBD(forwardBD), .forwardAE(forwardAE),
      .forwardBE(forwardBE), .forwardhiloE(forwardhiloE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
      .flushE(flushE), .div_start(div_start), .div_done(div_done)
   );

   always #5 clk = ~clk;

   // Divide bookkeeping: start at -1, run LAT busy cycles after the start, then done until memory releases
   always @(posedge clk or negedge rst) begin
      if (!rst) mDiv = -1;
      else if (mDiv < 0) begin
         if (divE) mDiv = 1;
      end else if (mDiv <= LAT) mDiv = mDiv + 1;
      else if (!dmem_stall) mDiv = -1;
   end

   function automatic logic [1:0] aluSel(input logic [4:0] src);
      if (src != 0 && src == writeregM && regwriteM) return 2'b10;
      if (src != 0 && src == writeregW && regwriteW) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [15:0] expectedOutputs();
      logic start, busy, done, lw, br, fAD, fBD;
      logic [1:0] fh;
      logic [5:0] stalls;
      if (!rst) return 16'h0;
      start = (mDiv < 0) && divE;
      busy  = start || (mDiv >= 1 && mDiv <= LAT);
      done  = (mDiv == LAT + 1);
      lw = memtoregE && (rtE == rsD || rtE == rtD);
      br = (branchD || jalrD) &&
           ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
            (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
      fAD = regwriteM && rsD != 0 && rsD == writeregM;
      fBD = regwriteM && rtD != 0 && rtD == writeregM;
      fh  = (hiloreadE && hilowriteM) ? 2'b10 : (hilowriteW ? 2'b01 : 2'b00);
      if (dmem_stall || busy) stalls = 6'b111110;
      else if (lw || br)      stalls = 6'b110001;
      else                    stalls = 6'b000000;
      return {fAD, fBD, aluSel(rsE), aluSel(rtE), fh, stalls, start, done};
   endfunction

   task automatic applyStimulus(input bit randomize);
      @(posedge clk);
      #1;
      rsD = '0; rtD = '0; rsE = '0; rtE = '0;
      writeregE = '0; writeregM = '0; writeregW = '0;
      {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
      {branchD, jalrD, hiloreadE, hilowriteM, hilowriteW, divE, dmem_stall} = '0;
      if (randomize) begin
         rsD = 5'($urandom_range(0, 7)); rtD = 5'($urandom_range(0, 7));
         rsE = 5'($urandom_range(0, 7)); rtE = 5'($urandom_range(0, 7));
         writeregE = 5'($urandom_range(0, 7)); writeregM = 5'($urandom_range(0, 7));
         writeregW = 5'($urandom_range(0, 7));
         {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = 5'($urandom);
         {branchD, jalrD, hiloreadE, hilowriteM, hilowriteW} = 5'($urandom);
         divE       = ($urandom_range(0, 7) == 0);
         dmem_stall = ($urandom_range(0, 4) == 0);
      end
   endtask

   task automatic checkOutput();
      logic [15:0] want;
      @(negedge clk);
      want = expectedOutputs();
      checks++;
      startSeen += int'(div_start);
      if (dutVec !== want) begin
         errors++;
         $display("[TB] FAIL outputs t=%0t got=%h want=%h", $time, dutVec, want);
      end
   endtask

   task automatic expectVal(input string name, input logic [15:0] actual, input logic [15:0] want);
      checks++;
      if (actual !== want) begin
         errors++;
         $display("[TB] FAIL %s got=%h want=%h", name, actual, want);
      end
   endtask

   initial begin
      // Outputs stay gated while reset is held, even with hazards present
      #2;
      divE = 1; dmem_stall = 1; rsE = 3; writeregM = 3; regwriteM = 1;
      #6;
      expectVal("reset_outputs", dutVec, 16'h0);
      checkOutput();

      applyStimulus(0);
      rst = 1;
      rsE = 3; rtE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
      checkOutput();
      expectVal("fwdAE_mem_priority", 16'(forwardAE), 16'h2);
      expectVal("fwdBE_mem_priority", 16'(forwardBE), 16'h2);
      applyStimulus(0);
      rsE = 3; writeregM = 3; writeregW = 3; regwriteW = 1;
      checkOutput();
      expectVal("fwdAE_wb", 16'(forwardAE), 16'h1);
      applyStimulus(0);
      rsE = 0; writeregM = 0; regwriteM = 1;
      checkOutput();
      expectVal("fwdAE_reg0", 16'(forwardAE), 16'h0);

      applyStimulus(0);
      memtoregE = 1; rtE = 5; rtD = 5;
      checkOutput();
      expectVal("lwstall", 16'({stallF, stallD, stallE, stallM, stallW, flushE}), 16'b110001);
      applyStimulus(0);
      rtD = 5;
      checkOutput();
      expectVal("lwstall_one_cycle", 16'({stallF, stallD, flushE}), 16'h0);

      applyStimulus(0);
      branchD = 1; rsD = 7; writeregE = 7; regwriteE = 1;
      checkOutput();
      expectVal("brstall", 16'({stallD, flushE, forwardAD}), 16'b110);
      applyStimulus(0);
      branchD = 1; rsD = 7; writeregM = 7; regwriteM = 1;
      checkOutput();
      expectVal("br_forwardAD", 16'({stallD, forwardAD}), 16'b01);

      // Divide with no memory wait: start at cycle 0, busy through 4, done at 5
      for (int c = 0; c <= LAT + 2; c++) begin
         applyStimulus(0);
         divE = (c <= LAT + 1);
         checkOutput();
         if (c == 0) expectVal("div_start_c0", 16'({div_start, stallF, stallW, flushE}), 16'b1110);
         else if (c <= LAT) expectVal("div_busy_cycle", 16'({div_start, stallE, div_done}), 16'b010);
         else if (c == LAT + 1) expectVal("div_done_c5", 16'({div_done, stallF}), 16'b10);
         else expectVal("div_no_restart", 16'({div_start, div_done}), 16'h0);
      end

      // Memory wait during done holds the result and never restarts the divider
      startSeen = 0;
      for (int c = 0; c <= LAT + 5; c++) begin
         applyStimulus(0);
         divE = (c <= LAT + 4);
         dmem_stall = (c >= LAT + 1 && c <= LAT + 3);
         checkOutput();
         if (c >= LAT + 1 && c <= LAT + 3)
            expectVal("div_done_held", 16'({div_done, stallW, div_start}), 16'b110);
      end
      expectVal("single_div_start", 16'(startSeen), 16'h1);

      // Reset in the middle of a divide aborts it without a done pulse
      for (int c = 0; c <= 2; c++) begin
         applyStimulus(0);
         divE = 1;
         checkOutput();
      end
      #1 rst = 0;
      #1 expectVal("reset_mid_busy", dutVec, 16'h0);
      applyStimulus(0);
      rst = 1;
      for (int c = 0; c < LAT + 3; c++) begin
         checkOutput();
         if (c == LAT + 1) expectVal("no_done_after_abort", 16'({div_done, stallE}), 16'h0);
         applyStimulus(0);
      end

      for (int c = 0; c < 600; c++) begin
         applyStimulus(1);
         checkOutput();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
